// File: rtl/divider_checker.sv
// divider_checker
//   Rebuilds dividend = quotient * divisor + remainder with a sequential
//   shift-add multiplier. It raises error for any result that no legal
//   division could have produced: divisor zero, remainder >= divisor, or a
//   product that does not fit in WIDTH bits.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      request; accepted only in IDLE or DONE
//   quotient   multiplier operand, latched on the accepting edge
//   divisor    multiplicand, latched on the accepting edge
//   remainder  addend, latched on the accepting edge
//   dividend   low WIDTH bits of the reconstruction (registered)
//   error      illegal or overflowing reconstruction; valid while done=1
//   done       result valid; held until the next accepted start
//   busy       high while the multiply is running
//
// Build option
//   DIVIDER_CHECKER_EARLY_EXIT_EN : leave CALC as soon as the remaining
//   multiplier bits are all zero. The default build always takes WIDTH cycles.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start after reset
// CALC  | one shift-add step per clock
// DONE  | dividend/error valid and held; start restarts
module divider_checker #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] quotient,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] dividend,
    output logic             error,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mplier_next;
    logic [CW-1:0]      cnt_left;
    logic               bad_operands;
    logic               last_iter;

    // The accumulator is 2*WIDTH wide, so the full product plus the addend
    // always fits and the overflow check sees every carry.
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mplier_next = mplier >> 1;
`ifdef DIVIDER_CHECKER_EARLY_EXIT_EN
        last_iter   = (cnt_left == CNT_LAST) || (mplier_next == '0);
`else
        last_iter   = (cnt_left == CNT_LAST);
`endif
    end

    assign busy = (state == S_CALC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt_left     <= '0;
            bad_operands <= 1'b0;
            dividend     <= '0;
            error        <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        acc          <= {{WIDTH{1'b0}}, remainder};
                        mcand        <= {{WIDTH{1'b0}}, divisor};
                        mplier       <= quotient;
                        cnt_left     <= CNT_INIT;
                        // The divisor/remainder legality check only needs the
                        // latched operands, so it is resolved here once.
                        bad_operands <= (divisor == '0) || (remainder >= divisor);
                        done         <= 1'b0;
                        state        <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc      <= acc_next;
                    mcand    <= mcand << 1;
                    mplier   <= mplier_next;
                    cnt_left <= cnt_left - CNT_LAST;
                    if (last_iter) begin
                        dividend <= acc_next[WIDTH-1:0];
                        error    <= bad_operands || (acc_next[2*WIDTH-1:WIDTH] != '0);
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_checker.sv
module tb_divider_checker;

`ifdef DIVIDER_CHECKER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] quotient;
    logic [31:0] divisor;
    logic [31:0] remainder;
    logic [31:0] dividend;
    logic        error;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    divider_checker #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .quotient (quotient),
        .divisor  (divisor),
        .remainder(remainder),
        .dividend (dividend),
        .error    (error),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles from the accepting edge to done.
    function automatic int exp_latency(input logic [31:0] q);
        int top;
        top = 0;
        for (int i = 0; i < 32; i++)
            if (q[i]) top = i + 1;
        if (!EARLY) return 32;
        return (top < 1) ? 1 : top;
    endfunction

    // Called at posedge+1. Accepts one operation and follows it to DONE.
    task automatic run_op(input logic [31:0] q, input logic [31:0] d,
                          input logic [31:0] r, input bit pulse_mid);
        logic [63:0] full;
        logic [31:0] exp_div;
        logic        exp_err;
        int          lat;
        int          n;
        full    = 64'(q) * 64'(d) + 64'(r);
        exp_div = full[31:0];
        exp_err = (d == 0) || (r >= d) || (full[63:32] != 0);
        lat     = exp_latency(q);

        start = 1'b1; quotient = q; divisor = d; remainder = r;
        @(posedge clk); #1;
        start = 1'b0;
        quotient = $urandom; divisor = $urandom; remainder = $urandom;
        if (lat > 1) begin
            check_val("busy_after_accept", busy, 1);
            check_val("done_after_accept", done, 0);
        end
        n = 0;
        while (!done && n < 200) begin
            if (pulse_mid && n == 0 && lat > 1) begin
                start = 1'b1; quotient = 32'd9; divisor = 32'd11; remainder = 32'd2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check_val("timeout", done, 1);
        check_val("latency", n, lat);
        check_val("dividend", dividend, exp_div);
        check_val("error", error, exp_err);
        check_val("busy_in_done", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("hold_dividend", dividend, exp_div);
        check_val("hold_done", done, 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        quotient = '0; divisor = '0; remainder = '0;
        #12;
        check_val("rst_done", done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_dividend", dividend, 0);
        check_val("rst_error", error, 0);
        #10 reset = 1'b1;
        @(posedge clk); #1;
        check_val("idle_no_start", busy, 0);

        run_op(32'd447, 32'd101, 32'd87, 1'b0);
        run_op(32'd1234, 32'd0, 32'd0, 1'b0);
        run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
        run_op(32'h0000_FFFF, 32'h0001_0000, 32'd7, 1'b0);
        run_op(32'd5, 32'd7, 32'd7, 1'b0);

        // Asynchronous reset in the middle of CALC.
        start = 1'b1; quotient = 32'hFFFF_FFFF; divisor = 32'd77; remainder = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_val("abort_done", done, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_dividend", dividend, 0);
        #3 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_after_abort", busy, 0);
        check_val("no_done_after_abort", done, 0);

        run_op(32'd3, 32'd4, 32'd1, 1'b1);
        run_op(32'd17, 32'd23, 32'd4, 1'b0);

        run_op(32'd1, 32'd9, 32'd2, 1'b0);
        run_op(32'd0, 32'd6, 32'd5, 1'b0);
        run_op(32'h8000_0000, 32'd1, 32'd0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] q, d, r;
            case ($urandom_range(0, 2))
                0: begin q = $urandom; d = $urandom; r = $urandom; end
                1: begin
                    q = $urandom_range(0, 65535);
                    d = $urandom_range(1, 65535);
                    r = $urandom % d;
                end
                default: begin
                    q = 32'd1 << $urandom_range(0, 31);
                    d = $urandom_range(0, 3);
                    r = $urandom_range(0, 3);
                end
            endcase
            run_op(q, d, r, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/divider_checker.md
Name: divider_checker

Overview:
- Inverse of the `divider` block: rebuilds dividend = quotient*divisor + remainder using a sequential shift-add multiplier, with a start/done handshake.
- Flags any result that could not have come from a legal division.
- Sits beside `divider` in the datapath and in self-checking benches; its `dividend` output is compared against the divider's original operand.

Parameters:
- WIDTH, 32, bit width of quotient, divisor, remainder and dividend; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request; sampled only in IDLE or DONE
- quotient  input  WIDTH  multiplier operand; sampled on the accepting edge
- divisor  input  WIDTH  multiplicand; sampled on the accepting edge
- remainder  input  WIDTH  addend; sampled on the accepting edge
- dividend  output  WIDTH  low WIDTH bits of the reconstructed value; registered
- error  output  1  illegal or overflowing reconstruction; valid while done=1
- done  output  1  result valid; level signal, held until the next accepted start
- busy  output  1  high in CALC

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE
  - dividend=0, error=0, done=0, busy=0
  - all internal registers cleared
- Reset mid-operation aborts the operation immediately. After release, the block idles until a new start.
- States: IDLE, CALC, DONE.
- Accept (edge t0): start=1 while in IDLE or DONE.
  - Latch operands.
  - acc (2*WIDTH bits) = zero-extended remainder.
  - mcand (2*WIDTH bits) = zero-extended divisor.
  - mplier = quotient; iteration counter = 0.
  - done=0, busy=1, state=CALC.
- CALC, each edge:
  - If mplier[0]=1, acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, counter += 1.
  - The addition is full 2*WIDTH-bit; no carry is ever lost.
- Exit CALC: on the edge where counter reaches WIDTH, i.e. edge t0+WIDTH. On that same edge:
  - dividend = acc_next[WIDTH-1:0]
  - error computed (see below)
  - done=1, busy=0, state=DONE
- Latency: done visible WIDTH clocks after the accepting edge (WIDTH=32: 32 clocks).
- error=1 if any of the following holds:
  - (a) latched divisor == 0
  - (b) latched remainder >= latched divisor
  - (c) acc_next[2*WIDTH-1:WIDTH] != 0 (overflow)
  - Otherwise error=0.
  - dividend always carries the low WIDTH bits, even when error=1.
- start while in CALC is ignored; the operation continues unchanged and no queueing occurs.
- start=1 in DONE restarts; done drops on that same edge.
- In DONE, dividend and error hold stable until the next accept or reset.
- Operand inputs may change freely after the accepting edge without affecting the result.

Optional Feature:
- Macro: DIVIDER_CHECKER_EARLY_EXIT_EN.
- Defined:
  - CALC also exits on the first edge where the shifted mplier becomes 0.
  - Minimum 1 CALC cycle; latency = max(1, index of highest set bit of quotient + 1) clocks.
  - quotient=0 gives done after 1 clock with dividend=remainder.
  - Results and error are identical to the fixed-latency build.
- Not defined: latency is always exactly WIDTH clocks.

Test Plan:
- WIDTH=32: quotient=447, divisor=101, remainder=87, start pulsed for one clock -> busy=1 for 32 clocks, then done=1, dividend=45234, error=0.
- quotient=1234, divisor=0, remainder=0 -> done after 32 clocks, dividend=0, error=1.
- quotient=32'h0001_0000, divisor=32'h0001_0000, remainder=0 -> dividend=0, error=1 (overflow). Repeat with remainder=7, divisor=32'h0001_0000, quotient=32'h0000_FFFF -> dividend=32'hFFFF_0007, error=0.
- quotient=5, divisor=7, remainder=7 -> dividend=42, error=1 (remainder >= divisor).
- Start a run; assert reset=0 asynchronously 10 clocks in -> done=0, busy=0, dividend=0 with no clock edge. After release, start quotient=3, divisor=4, remainder=1 -> dividend=13, error=0. Pulse start again mid-CALC with different operands -> ignored; result still 13. Then start from DONE -> done falls on the accepting edge.
- With DIVIDER_CHECKER_EARLY_EXIT_EN:
  - quotient=1, divisor=9, remainder=2 -> done after 1 clock, dividend=11.
  - quotient=0, remainder=5, divisor=6 -> done after 1 clock, dividend=5, error=0.
  - quotient=32'h8000_0000, divisor=1 -> done after 32 clocks.
